// File: rtl/sram_capture_responder.sv
// Tiled ADC frame capture memory with JTAG random-access readback; reads are registered (latency 1).
// No backpressure: every in_valid frame during CAPTURE is written, and reads are ignored while capturing.
module sram_capture_responder #(
  parameter int N_mem_tiles = 4,
  parameter int N_mem_addr  = 10,
  parameter int Nadc        = 8,
  parameter int Nti         = 16,
  parameter int Nti_rep     = 2,
  localparam int LT    = $clog2(N_mem_tiles),
  localparam int AW    = N_mem_addr + LT,
  localparam int NS    = Nti + Nti_rep,
  localparam int DEPTH = 2 ** AW,
  localparam int WW    = NS * Nadc
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [Nadc-1:0] in_data [NS],
  input  logic                   in_valid,
  input  logic                   start_capture,
  input  logic        [AW-1:0]   in_addr,
  input  logic                   sel_sram,
  output logic signed [Nadc-1:0] out_data [NS],
  output logic        [AW-1:0]   addr,
  output logic                   capture_done
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   wp, wp_nxt;
  logic            wr_en;
  logic            rd_en;
  logic            done_nxt;
  logic [WW-1:0]   wr_word;
  logic [WW-1:0]   rd_q;
  logic [WW-1:0]   mem [DEPTH];

  always_comb begin
    state_nxt = state;
    wp_nxt    = wp;
    wr_en     = 1'b0;
    done_nxt  = capture_done;
    case (state)
      IDLE, DONE: begin
        // The arming cycle never writes, even if in_valid is high.
        if (start_capture) begin
          state_nxt = CAPTURE;
          wp_nxt    = '0;
          done_nxt  = 1'b0;
        end
      end
      CAPTURE: begin
        if (in_valid) begin
          wr_en  = 1'b1;
          wp_nxt = wp + 1'b1;
          if (wp == '1) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_en = sel_sram && (state != CAPTURE);

  always_comb begin
    wr_word = '0;
    for (int k = 0; k < NS; k++) begin
      wr_word[k*Nadc +: Nadc] = in_data[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wp           <= '0;
      addr         <= '0;
      capture_done <= 1'b0;
      rd_q         <= '0;
    end else begin
      state        <= state_nxt;
      wp           <= wp_nxt;
      capture_done <= done_nxt;
      if (wr_en) addr <= wp;
      if (rd_en) rd_q <= mem[in_addr];
    end
  end

  // Storage carries no reset; contents are only meaningful after a capture.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_word;
  end

  for (genvar k = 0; k < NS; k++) begin : g_unpack
    assign out_data[k] = rd_q[k*Nadc +: Nadc];
  end

endmodule
